// File: rtl/tank_sprite_pkg.sv
// Shared types and constants for the tank sprite layer: facing directions,
// frame layout of the sprite ROM and screen geometry.
package tank_sprite_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam int NUM_FRAMES     = 8;
  localparam int FRAMES_PER_DIR = 2;
  localparam int FRAME_W        = $clog2(NUM_FRAMES);
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;

  // Each facing owns two consecutive frames; the tread animation bit picks one.
  function automatic logic [FRAME_W-1:0] frame_of(input dir_t d, input logic anim);
    return FRAME_W'(d) * FRAME_W'(FRAMES_PER_DIR) + FRAME_W'(anim);
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Frame-synchronous shadow registers for the tank position and facing, plus the
// tread animation divider. Everything here only changes on frame_start.
module sprite_anim_ctrl
  import tank_sprite_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [9:0]         req_x,
  input  logic [9:0]         req_y,
  input  dir_t               req_dir,
  input  logic               moving,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic [FRAME_W-1:0] frame
);

  localparam int CNT_W = 8;

  dir_t             dir;
  logic             anim;
  logic [CNT_W-1:0] anim_cnt;

  // Latch on frame_start only, so a frame is never rendered with mixed state.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x    <= '0;
      pos_y    <= '0;
      dir      <= UP;
      anim     <= 1'b0;
      anim_cnt <= '0;
    end else if (frame_start) begin
      pos_x <= req_x;
      pos_y <= req_y;
      dir   <= req_dir;
      if (moving) begin
        if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
          anim_cnt <= '0;
          anim     <= ~anim;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
      end
    end
  end

  assign frame = frame_of(dir, anim);

endmodule

// File: rtl/tank_sprite_renderer.sv
// Tank sprite pixel generator: box test and ROM addressing in stage 1, ROM read
// in stage 2, transparency keying and output register in stage 3.
module tank_sprite_renderer
  import tank_sprite_pkg::*;
#(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int SCALE_SHIFT = 1,
  parameter int IDX_W       = 4,
  parameter int TRANSP_IDX  = 0,
  parameter int ANIM_DIV    = 8,
  parameter int ADDR_W      = $clog2(8 * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  dir_t              dir,
  input  logic              moving,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_hit,
  output logic              pix_valid
);

  localparam int BOX_W     = SPR_W << SCALE_SHIFT;
  localparam int BOX_H     = SPR_H << SCALE_SHIFT;
  localparam int FRAME_TEX = SPR_W * SPR_H;

  logic [9:0]         act_x;
  logic [9:0]         act_y;
  logic [FRAME_W-1:0] frame;

  sprite_anim_ctrl #(
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .req_x      (pos_x),
    .req_y      (pos_y),
    .req_dir    (dir),
    .moving     (moving),
    .pos_x      (act_x),
    .pos_y      (act_y),
    .frame      (frame)
  );

  // The box test runs in 11 bits so a sprite near the right/bottom edge
  // clips instead of wrapping around to column/row 0.
  logic [10:0] x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
  logic        in_box;
  logic [9:0]  dx, dy, lx, ly;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    x_lo   = {1'b0, act_x};
    y_lo   = {1'b0, act_y};
    x_hi   = x_lo + 11'(BOX_W);
    y_hi   = y_lo + 11'(BOX_H);
    in_box = (x_ext >= x_lo) && (x_ext < x_hi) && (y_ext >= y_lo) && (y_ext < y_hi);
    dx     = DrawX - act_x;
    dy     = DrawY - act_y;
    lx     = dx >> SCALE_SHIFT;
    ly     = dy >> SCALE_SHIFT;
    addr_next = '0;
    if (in_box) begin
      addr_next = ADDR_W'(frame) * ADDR_W'(FRAME_TEX)
                + ADDR_W'(ly) * ADDR_W'(SPR_W)
                + ADDR_W'(lx);
    end
  end

  logic in_box_d1, blank_d1;
  logic in_box_d2, blank_d2;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      in_box_d1   <= 1'b0;
      blank_d1    <= 1'b0;
      in_box_d2   <= 1'b0;
      blank_d2    <= 1'b0;
    end else begin
      rom_address <= addr_next;
      in_box_d1   <= in_box;
      blank_d1    <= blank;
      in_box_d2   <= in_box_d1;
      blank_d2    <= blank_d1;
    end
  end

  // rom_q lines up with the *_d2 flags; a non-hit always presents index 0.
  logic hit_next;

  always_comb begin
    hit_next = in_box_d2 && blank_d2 && (rom_q != IDX_W'(TRANSP_IDX));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_idx   <= '0;
      pix_hit   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_idx   <= hit_next ? rom_q : '0;
      pix_hit   <= hit_next;
      pix_valid <= blank_d2;
    end
  end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Directed self-checking bench for tank_sprite_renderer with a behavioural
// synchronous ROM returning either a fixed index or the address low nibble.
module tb_tank_sprite_renderer;
  import tank_sprite_pkg::*;

  localparam int ADDR_W = 13;

  logic              vga_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [9:0]        DrawX = '0;
  logic [9:0]        DrawY = '0;
  logic              blank = 1'b0;
  logic              frame_start = 1'b0;
  logic [9:0]        pos_x = '0;
  logic [9:0]        pos_y = '0;
  dir_t              dir = UP;
  logic              moving = 1'b0;
  logic [ADDR_W-1:0] rom_address;
  logic [3:0]        rom_q;
  logic [3:0]        pix_idx;
  logic              pix_hit;
  logic              pix_valid;

  int         vectors = 0;
  int         miscompares = 0;
  logic       rom_mode = 1'b0;
  logic [3:0] rom_fill = 4'd0;

  tank_sprite_renderer dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .frame_start(frame_start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .moving     (moving),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .pix_idx    (pix_idx),
    .pix_hit    (pix_hit),
    .pix_valid  (pix_valid)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    rom_q <= rom_mode ? rom_address[3:0] : rom_fill;
  end

  task automatic drive_pixel(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  task automatic pulse_frame_start();
    @(negedge vga_clk);
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rom_mode = 1'b0;
    rom_fill = 4'd5;
    repeat (3) @(negedge vga_clk);
    vectors++;
    if ({rom_address, pix_idx, pix_hit, pix_valid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got addr=%0d idx=%0d hit=%0b valid=%0b, expected all 0",
               rom_address, pix_idx, pix_hit, pix_valid);
    end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge vga_clk);
      reset_n = 1'b1;
      drive_pixel(5, 5, 1'b1);
      @(negedge vga_clk);
      vectors++;
      if (rom_address !== 13'd66) begin
        miscompares++;
        $display("[TB] FAIL reset_first_addr: got %0d expected 66", rom_address);
      end
      @(negedge vga_clk);
      vectors++;
      if (pix_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_valid_early: got %0b expected 0", pix_valid);
      end
      @(negedge vga_clk);
      vectors++;
      if (pix_valid !== 1'b1 || pix_hit !== 1'b1 || pix_idx !== 4'd5) begin
        miscompares++;
        $display("[TB] FAIL reset_valid_rise: got valid=%0b hit=%0b idx=%0d expected 1 1 5",
                 pix_valid, pix_hit, pix_idx);
      end
      if (pass == 0) begin
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({rom_address, pix_idx, pix_hit, pix_valid} !== '0) begin
          miscompares++;
          $display("[TB] FAIL reset_midline: got addr=%0d idx=%0d hit=%0b valid=%0b, expected all 0",
                   rom_address, pix_idx, pix_hit, pix_valid);
        end
      end
    end
  endtask

  task automatic test_address();
    int   vx[6] = '{100, 163, 164,  99, 120, 130};
    int   vy[6] = '{ 50, 113,  60,  60, 114,  80};
    logic vb[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   ea[6] = '{6144, 7167, 0, 0, 0, 6639};
    logic eh[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int   ei[6] = '{5, 5, 0, 0, 0, 0};
    pos_x    = 10'd100;
    pos_y    = 10'd50;
    dir      = LEFT;
    moving   = 1'b0;
    rom_fill = 4'd5;
    pulse_frame_start();
    for (int i = 0; i < 6; i++) begin
      drive_pixel(vx[i], vy[i], vb[i]);
      @(negedge vga_clk);
      vectors++;
      if (rom_address !== ADDR_W'(ea[i])) begin
        miscompares++;
        $display("[TB] FAIL addr_%0d: got %0d expected %0d", i, rom_address, ea[i]);
      end
      repeat (2) @(negedge vga_clk);
      vectors++;
      if (pix_hit !== eh[i] || pix_idx !== 4'(ei[i]) || pix_valid !== vb[i]) begin
        miscompares++;
        $display("[TB] FAIL pix_%0d: got hit=%0b idx=%0d valid=%0b expected %0b %0d %0b",
                 i, pix_hit, pix_idx, pix_valid, eh[i], ei[i], vb[i]);
      end
    end
  endtask

  task automatic test_transparency();
    rom_fill = 4'd0;
    drive_pixel(110, 60, 1'b0);
    repeat (3) @(negedge vga_clk);
    drive_pixel(110, 60, 1'b1);
    repeat (3) @(negedge vga_clk);
    vectors++;
    if (pix_hit !== 1'b0 || pix_idx !== 4'd0 || pix_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL transparent: got hit=%0b idx=%0d valid=%0b expected 0 0 1",
               pix_hit, pix_idx, pix_valid);
    end
    rom_fill = 4'd5;
    drive_pixel(110, 60, 1'b0);
    repeat (3) @(negedge vga_clk);
    drive_pixel(110, 60, 1'b1);
    repeat (2) @(negedge vga_clk);
    vectors++;
    if (pix_hit !== 1'b0 || pix_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL opaque_early: got hit=%0b valid=%0b expected 0 0", pix_hit, pix_valid);
    end
    @(negedge vga_clk);
    vectors++;
    if (pix_hit !== 1'b1 || pix_idx !== 4'd5 || pix_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL opaque: got hit=%0b idx=%0d valid=%0b expected 1 5 1",
               pix_hit, pix_idx, pix_valid);
    end
  endtask

  task automatic test_anim();
    // Bit i belongs to frame_start pulse i+1.
    logic [25:0] mov_seq = 26'b11111_00_1111111111111111111;
    logic [25:0] exp_seq = 26'b1_0000000000_11111111_0000000;
    logic [ADDR_W-1:0] exp_addr;
    rom_fill = 4'd5;
    drive_pixel(100, 50, 1'b1);
    for (int i = 0; i < 26; i++) begin
      moving = mov_seq[i];
      pulse_frame_start();
      @(negedge vga_clk);
      exp_addr = exp_seq[i] ? 13'd7168 : 13'd6144;
      vectors++;
      if (rom_address !== exp_addr) begin
        miscompares++;
        $display("[TB] FAIL anim_pulse_%0d: got %0d expected %0d", i + 1, rom_address, exp_addr);
      end
    end
    pos_x  = 10'd200;
    pos_y  = 10'd300;
    dir    = UP;
    moving = 1'b1;
    repeat (3) @(negedge vga_clk);
    vectors++;
    if (rom_address !== 13'd7168 || pix_hit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL no_tearing: got addr=%0d hit=%0b expected 7168 1", rom_address, pix_hit);
    end
    moving = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ex[12] = '{96, 97, 98, 99, 100, 101, 102, 103, 104, 105, 106, 107};
    int ea[12] = '{0, 0, 0, 0, 7168, 7168, 7169, 7169, 7170, 7170, 7171, 7171};
    int ei[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3};
    rom_mode = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge vga_clk);
      if (c >= 1 && c <= 12) begin
        vectors++;
        if (rom_address !== ADDR_W'(ea[c-1])) begin
          miscompares++;
          $display("[TB] FAIL b2b_addr_%0d: got %0d expected %0d", c - 1, rom_address, ea[c-1]);
        end
      end
      if (c >= 3) begin
        vectors++;
        if (pix_idx !== 4'(ei[c-3]) || pix_hit !== (ei[c-3] != 0) || pix_valid !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_pix_%0d: got idx=%0d hit=%0b valid=%0b expected %0d %0b 1",
                   c - 3, pix_idx, pix_hit, pix_valid, ei[c-3], ei[c-3] != 0);
        end
      end
      if (c < 12) drive_pixel(ex[c], 51, 1'b1);
      else        drive_pixel(0, 0, 1'b0);
    end
    rom_mode = 1'b0;
  endtask

  task automatic test_clip();
    int   vx[6] = '{620, 639, 619,   0, 630, 625};
    int   vy[6] = '{470, 479, 475, 470, 469, 475};
    logic vb[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   ea[6] = '{1024, 1161, 0, 0, 0, 1090};
    logic eh[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int   ei[6] = '{9, 9, 0, 0, 0, 0};
    pos_x    = 10'd620;
    pos_y    = 10'd470;
    dir      = UP;
    moving   = 1'b0;
    rom_fill = 4'd9;
    pulse_frame_start();
    for (int i = 0; i < 6; i++) begin
      drive_pixel(vx[i], vy[i], vb[i]);
      @(negedge vga_clk);
      vectors++;
      if (rom_address !== ADDR_W'(ea[i])) begin
        miscompares++;
        $display("[TB] FAIL clip_addr_%0d: got %0d expected %0d", i, rom_address, ea[i]);
      end
      repeat (2) @(negedge vga_clk);
      vectors++;
      if (pix_hit !== eh[i] || pix_idx !== 4'(ei[i]) || pix_valid !== vb[i]) begin
        miscompares++;
        $display("[TB] FAIL clip_pix_%0d: got hit=%0b idx=%0d valid=%0b expected %0b %0d %0b",
                 i, pix_hit, pix_idx, pix_valid, eh[i], ei[i], vb[i]);
      end
    end
  endtask

  task automatic test_frame_start_overlap();
    pos_x = 10'd100;
    pos_y = 10'd50;
    dir   = DOWN;
    @(negedge vga_clk);
    frame_start = 1'b1;
    drive_pixel(100, 50, 1'b1);
    @(negedge vga_clk);
    frame_start = 1'b0;
    vectors++;
    if (rom_address !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL overlap_old: got %0d expected 0", rom_address);
    end
    @(negedge vga_clk);
    vectors++;
    if (rom_address !== 13'd5120) begin
      miscompares++;
      $display("[TB] FAIL overlap_new: got %0d expected 5120", rom_address);
    end
  endtask

  initial begin
    test_reset();
    test_address();
    test_transparency();
    test_anim();
    test_back_to_back();
    test_clip();
    test_frame_start_overlap();
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
